// File: rtl/regfile_fwd_pkg.sv
// +-----------------------------------------------------------------------------+
// | regfile_fwd_pkg : shared constants and types for the forwarding regfile     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package regfile_fwd_pkg;

   localparam int DEF_REG_NUM    = 32;
   localparam int DEF_REG_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   // Which value a read port ends up returning
   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_EX   = 3'd1,
      SRC_MEM  = 3'd2,
      SRC_WB   = 3'd3,
      SRC_REG  = 3'd4
   } fwd_src_e;

endpackage

`default_nettype wire

// File: rtl/regfile_fwd_if.sv
// +-----------------------------------------------------------------------------+
// | regfile_fwd_if : read ports, EX/MEM/WB result triples and debug port        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface regfile_fwd_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int REG_WIDTH  = 32
);
   logic                  re1;
   logic [ADDR_WIDTH-1:0] raddr1;
   logic [REG_WIDTH-1:0]  rdata1;
   logic                  re2;
   logic [ADDR_WIDTH-1:0] raddr2;
   logic [REG_WIDTH-1:0]  rdata2;
   logic                  ex_we;
   logic [ADDR_WIDTH-1:0] ex_waddr;
   logic [REG_WIDTH-1:0]  ex_wdata;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [REG_WIDTH-1:0]  mem_wdata;
   logic                  wb_we;
   logic [ADDR_WIDTH-1:0] wb_waddr;
   logic [REG_WIDTH-1:0]  wb_wdata;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [REG_WIDTH-1:0]  dbg_data;

   modport master (
      output re1, raddr1, re2, raddr2,
      output ex_we, ex_waddr, ex_wdata,
      output mem_we, mem_waddr, mem_wdata,
      output wb_we, wb_waddr, wb_wdata,
      output dbg_addr,
      input  rdata1, rdata2, dbg_data
   );

   modport slave (
      input  re1, raddr1, re2, raddr2,
      input  ex_we, ex_waddr, ex_wdata,
      input  mem_we, mem_waddr, mem_wdata,
      input  wb_we, wb_waddr, wb_wdata,
      input  dbg_addr,
      output rdata1, rdata2, dbg_data
   );
endinterface

`default_nettype wire

// File: rtl/regfile_fwd_fwd_sel.sv
// +-----------------------------------------------------------------------------+
// | regfile_fwd_fwd_sel : per-port priority forward mux (EX > MEM > WB > store) |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module regfile_fwd_fwd_sel
   import regfile_fwd_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  wire logic              re_i,
   input  wire logic [ADDR_W-1:0] raddr_i,
   input  wire logic              ex_we_i,
   input  wire logic [ADDR_W-1:0] ex_waddr_i,
   input  wire logic [DATA_W-1:0] ex_wdata_i,
   input  wire logic              mem_we_i,
   input  wire logic [ADDR_W-1:0] mem_waddr_i,
   input  wire logic [DATA_W-1:0] mem_wdata_i,
   input  wire logic              wb_we_i,
   input  wire logic [ADDR_W-1:0] wb_waddr_i,
   input  wire logic [DATA_W-1:0] wb_wdata_i,
   input  wire logic [DATA_W-1:0] store_i,
   output logic      [DATA_W-1:0] data_o
);

   fwd_src_e w_src;

   // raddr_i is non-zero inside the branch, so a source aimed at $0 can never match
   always_comb begin
      w_src = SRC_NONE;
      if (re_i && (raddr_i != '0)) begin
         if (ex_we_i && (ex_waddr_i == raddr_i)) begin
            w_src = SRC_EX;
         end else if (mem_we_i && (mem_waddr_i == raddr_i)) begin
            w_src = SRC_MEM;
         end else if (wb_we_i && (wb_waddr_i == raddr_i)) begin
            w_src = SRC_WB;
         end else begin
            w_src = SRC_REG;
         end
      end
   end

   always_comb begin
      data_o = '0;
      case (w_src)
         SRC_EX:  data_o = ex_wdata_i;
         SRC_MEM: data_o = mem_wdata_i;
         SRC_WB:  data_o = wb_wdata_i;
         SRC_REG: data_o = store_i;
         default: data_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/regfile_fwd.sv
// +-----------------------------------------------------------------------------+
// | regfile_fwd : MIPS register file, WB-clocked storage, EX/MEM/WB forwarding  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int REG_NUM    = DEF_REG_NUM,
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  wire logic    clk,
   input  wire logic    rst,
   regfile_fwd_if.slave bus
);

   logic [REG_WIDTH-1:0] regs_q [REG_NUM];
   logic [REG_WIDTH-1:0] w_fwd1;
   logic [REG_WIDTH-1:0] w_fwd2;

   // Reset outranks a same-cycle write; entry 0 is never written
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else if (bus.wb_we && (bus.wb_waddr != '0)) begin
         regs_q[bus.wb_waddr] <= bus.wb_wdata;
      end
   end

   regfile_fwd_fwd_sel #(
      .ADDR_W (ADDR_WIDTH),
      .DATA_W (REG_WIDTH)
   ) u_sel1 (
      .re_i        (bus.re1),
      .raddr_i     (bus.raddr1),
      .ex_we_i     (bus.ex_we),
      .ex_waddr_i  (bus.ex_waddr),
      .ex_wdata_i  (bus.ex_wdata),
      .mem_we_i    (bus.mem_we),
      .mem_waddr_i (bus.mem_waddr),
      .mem_wdata_i (bus.mem_wdata),
      .wb_we_i     (bus.wb_we),
      .wb_waddr_i  (bus.wb_waddr),
      .wb_wdata_i  (bus.wb_wdata),
      .store_i     (regs_q[bus.raddr1]),
      .data_o      (w_fwd1)
   );

   regfile_fwd_fwd_sel #(
      .ADDR_W (ADDR_WIDTH),
      .DATA_W (REG_WIDTH)
   ) u_sel2 (
      .re_i        (bus.re2),
      .raddr_i     (bus.raddr2),
      .ex_we_i     (bus.ex_we),
      .ex_waddr_i  (bus.ex_waddr),
      .ex_wdata_i  (bus.ex_wdata),
      .mem_we_i    (bus.mem_we),
      .mem_waddr_i (bus.mem_waddr),
      .mem_wdata_i (bus.mem_wdata),
      .wb_we_i     (bus.wb_we),
      .wb_waddr_i  (bus.wb_waddr),
      .wb_wdata_i  (bus.wb_wdata),
      .store_i     (regs_q[bus.raddr2]),
      .data_o      (w_fwd2)
   );

   assign bus.rdata1   = rst ? w_fwd1 : '0;
   assign bus.rdata2   = rst ? w_fwd2 : '0;
   assign bus.dbg_data = rst ? regs_q[bus.dbg_addr] : '0;

   // Idle sources may carry X addresses; an enabled one must not
   a_ex_addr_known:  assert property (@(posedge clk) disable iff (!rst)
                        bus.ex_we  |-> !$isunknown(bus.ex_waddr));
   a_mem_addr_known: assert property (@(posedge clk) disable iff (!rst)
                        bus.mem_we |-> !$isunknown(bus.mem_waddr));
   a_wb_addr_known:  assert property (@(posedge clk) disable iff (!rst)
                        bus.wb_we  |-> !$isunknown(bus.wb_waddr));

endmodule

`default_nettype wire

// File: tb/tb_regfile_fwd.sv
// +-----------------------------------------------------------------------------+
// | tb_regfile_fwd : directed table, reset corner cases and random vs model     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_fwd;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_fwd_if #(.ADDR_WIDTH(5), .REG_WIDTH(32)) bus ();

   regfile_fwd #(
      .REG_NUM    (32),
      .REG_WIDTH  (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        re1;  logic [4:0] ra1;
      logic        re2;  logic [4:0] ra2;
      logic        exw;  logic [4:0] exa;  logic [31:0] exd;
      logic        mmw;  logic [4:0] mma;  logic [31:0] mmd;
      logic        wbw;  logic [4:0] wba;  logic [31:0] wbd;
      logic [4:0]  dbg;
      logic        clk_after;
      logic [31:0] e1;   logic [31:0] e2;  logic [31:0] ed;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mdl [32];
   vec_t        vt [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Architectural view: newest in-flight producer wins, else the stored value
   function automatic logic [31:0] ref_read(input logic re, input logic [4:0] a);
      if (!rst || !re || a == 5'd0) return 32'h0;
      if (bus.ex_we  && bus.ex_waddr  == a) return bus.ex_wdata;
      if (bus.mem_we && bus.mem_waddr == a) return bus.mem_wdata;
      if (bus.wb_we  && bus.wb_waddr  == a) return bus.wb_wdata;
      return mdl[a];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      end else if (bus.wb_we && bus.wb_waddr != 5'd0) begin
         mdl[bus.wb_waddr] = bus.wb_wdata;
      end
      #1;
   endtask

   task automatic idle();
      bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
      bus.ex_we = 0;  bus.ex_waddr = 0;  bus.ex_wdata = 0;
      bus.mem_we = 0; bus.mem_waddr = 0; bus.mem_wdata = 0;
      bus.wb_we = 0;  bus.wb_waddr = 0;  bus.wb_wdata = 0;
      bus.dbg_addr = 0;
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      idle();
      rst = 1'b0;
      bus.re1 = 1; bus.raddr1 = 5'd5; bus.re2 = 1; bus.raddr2 = 5'd5;
      tick(); tick();
      chk("rst_rdata1", bus.rdata1, 32'h0);
      chk("rst_rdata2", bus.rdata2, 32'h0);

      // Write reg5, then reset with a write pending: both must be lost
      rst = 1'b1; idle();
      bus.wb_we = 1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'h1234;
      tick();
      idle(); bus.dbg_addr = 5'd5; #1;
      chk("pre_rst_dbg5", bus.dbg_data, 32'h1234);
      rst = 1'b0;
      bus.wb_we = 1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'h9999;
      bus.re1 = 1; bus.raddr1 = 5'd5; bus.re2 = 1; bus.raddr2 = 5'd5; #1;
      chk("in_rst_rdata1", bus.rdata1, 32'h0);
      chk("in_rst_rdata2", bus.rdata2, 32'h0);
      chk("in_rst_dbg", bus.dbg_data, 32'h0);
      tick(); tick();
      rst = 1'b1; bus.wb_we = 0; #1;
      chk("post_rst_dbg5", bus.dbg_data, 32'h0);
      chk("post_rst_rdata1", bus.rdata1, 32'h0);

      //            re1 ra1 re2 ra2  exw exa exd       mmw mma mmd      wbw wba wbd           dbg clk  e1            e2            ed
      vt[0]  = '{1, 3, 1, 3,  0, 0, 0,           0, 0, 0,        1, 3, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
      vt[1]  = '{1, 3, 0, 3,  0, 0, 0,           0, 0, 0,        0, 0, 0,            3, 1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vt[2]  = '{1, 7, 1, 7,  1, 7, 32'h1,       1, 7, 32'h2,    1, 7, 32'h3,        7, 0, 32'h1,        32'h1,        32'h0};
      vt[3]  = '{1, 7, 1, 7,  0, 7, 32'h1,       1, 7, 32'h2,    1, 7, 32'h3,        7, 0, 32'h2,        32'h2,        32'h0};
      vt[4]  = '{1, 7, 1, 7,  0, 7, 32'h1,       0, 7, 32'h2,    1, 7, 32'h3,        7, 1, 32'h3,        32'h3,        32'h0};
      vt[5]  = '{1, 7, 1, 7,  0, 0, 0,           0, 0, 0,        0, 0, 0,            7, 1, 32'h3,        32'h3,        32'h3};
      vt[6]  = '{1, 0, 1, 0,  1, 0, 32'hFFFFFFFF, 0, 0, 0,       1, 0, 32'hFFFFFFFF, 0, 1, 32'h0,        32'h0,        32'h0};
      vt[7]  = '{1, 0, 1, 0,  0, 0, 0,           0, 0, 0,        0, 0, 0,            0, 1, 32'h0,        32'h0,        32'h0};
      vt[8]  = '{1, 4, 0, 4,  0, 0, 0,           0, 0, 0,        1, 4, 32'hA5A5,     4, 1, 32'hA5A5,     32'h0,        32'h0};
      vt[9]  = '{0, 4, 0, 4,  0, 0, 0,           0, 0, 0,        0, 0, 0,            4, 0, 32'h0,        32'h0,        32'hA5A5};
      vt[10] = '{1, 3, 1, 4,  0, 0, 0,           0, 0, 0,        0, 0, 0,            4, 1, 32'hDEADBEEF, 32'hA5A5,     32'hA5A5};
      vt[11] = '{1, 3, 1, 3,  0, 0, 0,           1, 3, 32'hCAFE, 1, 3, 32'h1111,     3, 1, 32'hCAFE,     32'hCAFE,     32'hDEADBEEF};
      vt[12] = '{1, 3, 1, 7,  0, 0, 0,           0, 0, 0,        0, 0, 0,            3, 1, 32'h1111,     32'h3,        32'h1111};

      for (int k = 0; k < 13; k++) begin
         bus.re1 = vt[k].re1; bus.raddr1 = vt[k].ra1;
         bus.re2 = vt[k].re2; bus.raddr2 = vt[k].ra2;
         bus.ex_we  = vt[k].exw; bus.ex_waddr  = vt[k].exa; bus.ex_wdata  = vt[k].exd;
         bus.mem_we = vt[k].mmw; bus.mem_waddr = vt[k].mma; bus.mem_wdata = vt[k].mmd;
         bus.wb_we  = vt[k].wbw; bus.wb_waddr  = vt[k].wba; bus.wb_wdata  = vt[k].wbd;
         bus.dbg_addr = vt[k].dbg;
         #1;
         chk($sformatf("vec%0d_rdata1", k), bus.rdata1, vt[k].e1);
         chk($sformatf("vec%0d_rdata2", k), bus.rdata2, vt[k].e2);
         chk($sformatf("vec%0d_dbg", k), bus.dbg_data, vt[k].ed);
         if (vt[k].clk_after) tick();
      end

      for (int n = 0; n < 1000; n++) begin
         rst = ($urandom_range(0, 99) != 0);
         bus.re1 = ($urandom_range(0, 7) != 0); bus.raddr1 = rnd_addr();
         bus.re2 = ($urandom_range(0, 7) != 0); bus.raddr2 = rnd_addr();
         bus.ex_we  = 1'($urandom_range(0, 1)); bus.ex_waddr  = rnd_addr(); bus.ex_wdata  = $urandom;
         bus.mem_we = 1'($urandom_range(0, 1)); bus.mem_waddr = rnd_addr(); bus.mem_wdata = $urandom;
         bus.wb_we  = 1'($urandom_range(0, 1)); bus.wb_waddr  = rnd_addr(); bus.wb_wdata  = $urandom;
         bus.dbg_addr = rnd_addr();
         #1;
         chk($sformatf("rnd%0d_rdata1", n), bus.rdata1, ref_read(bus.re1, bus.raddr1));
         chk($sformatf("rnd%0d_rdata2", n), bus.rdata2, ref_read(bus.re2, bus.raddr2));
         chk($sformatf("rnd%0d_dbg", n), bus.dbg_data, rst ? mdl[bus.dbg_addr] : 32'h0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
